// File: rtl/pending_encoder_8to3_pkg.sv
// Shared constants, state encoding and helpers for the 8-to-3 pending request encoder.
package enc_pkg;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pending_encoder_8to3_prio.sv
// Combinational fixed-priority picker: index of the lowest (or highest) set bit of vec.
module prio_encoder8
    import enc_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b0
)
(
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scanning towards the winning end lets the last hit overwrite earlier ones.
    always_comb begin
        idx = '0;
        any = |vec;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/pending_encoder_8to3.sv
// Sticky request collector that serialises pending lines into 3-bit indices over valid/ready.
module pending_encoder_8to3
    import enc_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b0
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         overflow
);

    enc_state_t     state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   out_idx_q, out_idx_d;
    logic           overflow_q, overflow_d;

    logic [W-1:0]   winner;
    logic           winner_any;
    logic           load;
    logic [N-1:0]   load_mask;

    // Only the registered pending vector competes; fresh requests wait one cycle.
    prio_encoder8 #(
        .PRIORITY_HIGH (PRIORITY_HIGH)
    ) u_prio (
        .vec (pending_q),
        .idx (winner),
        .any (winner_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (winner_any) state_d = HOLD;
                end
                HOLD: begin
                    if (out_ready && !winner_any) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A held index never gets preempted; a new winner loads only on an empty or draining slot.
    always_comb begin
        out_valid = (state_q == HOLD);
        load      = 1'b0;
        if (!clr) begin
            unique case (state_q)
                IDLE:    load = winner_any;
                HOLD:    load = out_ready && winner_any;
                default: load = 1'b0;
            endcase
        end
        load_mask = load ? onehot(winner) : '0;
    end

    always_comb begin
        pending_d  = (pending_q & ~load_mask) | req_in;
        overflow_d = |(req_in & pending_q & ~load_mask);
        out_idx_d  = load ? winner : out_idx_q;
        if (clr) begin
            pending_d  = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            out_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            out_idx_q  <= out_idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_idx  = out_idx_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pending_encoder_8to3.sv
// Directed bench for pending_encoder_8to3: ordering, hold, overflow, re-request, clear, reset, high priority.
module tb_pending_encoder_8to3;
    import enc_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clr = 1'b0;
    logic [N-1:0] req_in = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         overflow;

    logic [N-1:0] req_h = '0;
    logic         ready_h = 1'b1;
    logic         valid_h;
    logic [W-1:0] idx_h;
    logic [N-1:0] pending_h;
    logic         overflow_h;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pending_encoder_8to3 #(.PRIORITY_HIGH(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    pending_encoder_8to3 #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_h),
        .clr       (clr),
        .out_valid (valid_h),
        .out_ready (ready_h),
        .out_idx   (idx_h),
        .pending   (pending_h),
        .overflow  (overflow_h)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        req_in = 8'hFF;
        #1 rst_n = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%0b exp=0", out_valid); end
        checks++; if (out_idx !== 3'd0) begin failures++; $display("[TB] FAIL rst_idx got=%0d exp=0", out_idx); end
        checks++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL rst_pending got=%02h exp=00", pending); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rst_overflow got=%0b exp=0", overflow); end
        checks++; if ({valid_h, idx_h, pending_h} !== 12'h000) begin failures++; $display("[TB] FAIL rst_hi got=%03h exp=000", {valid_h, idx_h, pending_h}); end
        req_in = '0;
        rst_n  = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_seq [3] = '{3'd2, 3'd5, 3'd7};
        out_ready = 1'b1;
        req_in    = 8'b1010_0100;
        step();
        req_in = '0;
        checks++; if (pending !== 8'hA4) begin failures++; $display("[TB] FAIL b2b_pending got=%02h exp=a4", pending); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_latency got=%0b exp=0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, out_idx} !== {1'b1, exp_seq[i]}) begin
                failures++;
                $display("[TB] FAIL b2b_seq%0d got valid=%0b idx=%0d exp valid=1 idx=%0d", i, out_valid, out_idx, exp_seq[i]);
            end
        end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain_valid got=%0b exp=0", out_valid); end
        checks++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL b2b_drain_pending got=%02h exp=00", pending); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        req_in    = 8'h20;
        step();
        req_in = '0;
        step();
        for (int c = 0; c < 5; c++) begin
            req_in = (c == 1) ? 8'h01 : 8'h00;
            step();
            checks++;
            if ({out_valid, out_idx} !== {1'b1, 3'd5}) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d got valid=%0b idx=%0d exp valid=1 idx=5", c, out_valid, out_idx);
            end
        end
        req_in = '0;
        checks++; if (pending !== 8'h01) begin failures++; $display("[TB] FAIL hold_pending got=%02h exp=01", pending); end
        out_ready = 1'b1;
        step();
        checks++; if ({out_valid, out_idx} !== {1'b1, 3'd0}) begin failures++; $display("[TB] FAIL hold_next got valid=%0b idx=%0d exp valid=1 idx=0", out_valid, out_idx); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        req_in    = 8'h01;
        step();
        req_in = '0;
        step();
        req_in = 8'h08;
        step();
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_first got=%0b exp=0", overflow); end
        checks++; if (pending !== 8'h08) begin failures++; $display("[TB] FAIL ovf_pending got=%02h exp=08", pending); end
        step();
        req_in = '0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_pulse got=%0b exp=1", overflow); end
        step();
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%0b exp=0", overflow); end
        out_ready = 1'b1;
        step();
        checks++; if ({out_valid, out_idx} !== {1'b1, 3'd3}) begin failures++; $display("[TB] FAIL ovf_serve got valid=%0b idx=%0d exp valid=1 idx=3", out_valid, out_idx); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_once got=%0b exp=0", out_valid); end
    endtask

    task automatic test_rerequest();
        out_ready = 1'b1;
        req_in    = 8'h04;
        step();
        step();
        req_in = '0;
        checks++; if ({out_valid, out_idx} !== {1'b1, 3'd2}) begin failures++; $display("[TB] FAIL rereq_first got valid=%0b idx=%0d exp valid=1 idx=2", out_valid, out_idx); end
        checks++; if (pending !== 8'h04) begin failures++; $display("[TB] FAIL rereq_pending got=%02h exp=04", pending); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rereq_overflow got=%0b exp=0", overflow); end
        step();
        checks++; if ({out_valid, out_idx} !== {1'b1, 3'd2}) begin failures++; $display("[TB] FAIL rereq_second got valid=%0b idx=%0d exp valid=1 idx=2", out_valid, out_idx); end
        checks++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL rereq_empty got=%02h exp=00", pending); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rereq_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_clear_and_reset();
        out_ready = 1'b0;
        req_in    = 8'h40;
        step();
        req_in = '0;
        step();
        checks++; if ({out_valid, out_idx} !== {1'b1, 3'd6}) begin failures++; $display("[TB] FAIL clr_setup got valid=%0b idx=%0d exp valid=1 idx=6", out_valid, out_idx); end
        clr    = 1'b1;
        req_in = 8'hFF;
        step();
        clr    = 1'b0;
        req_in = '0;
        checks++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL clr_pending got=%02h exp=00", pending); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clr_valid got=%0b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL clr_overflow got=%0b exp=0", overflow); end
        checks++; if (out_idx !== 3'd6) begin failures++; $display("[TB] FAIL clr_idx_kept got=%0d exp=6", out_idx); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clr_stay_idle got=%0b exp=0", out_valid); end

        req_in = 8'h10;
        step();
        req_in = 8'h03;
        step();
        req_in = '0;
        checks++; if ({out_valid, out_idx, pending} !== {1'b1, 3'd4, 8'h03}) begin failures++; $display("[TB] FAIL rst_mid_setup got=%03h exp=c03", {out_valid, out_idx, pending}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_idx, pending, overflow} !== 13'h0) begin failures++; $display("[TB] FAIL rst_mid_async got=%04h exp=0000", {out_valid, out_idx, pending, overflow}); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_priority_high();
        logic [W-1:0] exp_seq [3] = '{3'd7, 3'd5, 3'd2};
        ready_h = 1'b1;
        req_h   = 8'b1010_0100;
        step();
        req_h = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({valid_h, idx_h} !== {1'b1, exp_seq[i]}) begin
                failures++;
                $display("[TB] FAIL hi_seq%0d got valid=%0b idx=%0d exp valid=1 idx=%0d", i, valid_h, idx_h, exp_seq[i]);
            end
        end
        step();
        checks++; if ({valid_h, pending_h} !== 9'h000) begin failures++; $display("[TB] FAIL hi_drain got=%03h exp=000", {valid_h, pending_h}); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_overflow();
        test_rerequest();
        test_clear_and_reset();
        test_priority_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
